// File: rtl/alu_operand_stage.sv
// Issue stage in front of the ALU: register file with write-back bypass, scoreboard
// for in-flight destinations, and a registered valid/ready payload toward the ALU.
module alu_operand_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  issue_valid,
  output logic                  issue_ready,
  input  logic [ADDR_WIDTH-1:0] issue_raddr1,
  input  logic [ADDR_WIDTH-1:0] issue_raddr2,
  input  logic                  issue_use_imm,
  input  logic [DATA_WIDTH-1:0] issue_imm,
  input  logic [2:0]            issue_aluop,
  input  logic [ADDR_WIDTH-1:0] issue_rd,
  input  logic                  wb_wen,
  input  logic [ADDR_WIDTH-1:0] wb_waddr,
  input  logic [DATA_WIDTH-1:0] wb_wdata,
  output logic                  ex_valid,
  input  logic                  ex_ready,
  output logic [DATA_WIDTH-1:0] ex_A,
  output logic [DATA_WIDTH-1:0] ex_B,
  output logic [2:0]            ex_ALUop,
  output logic [ADDR_WIDTH-1:0] ex_rd
);
  localparam int NREG = 1 << ADDR_WIDTH;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
    logic [2:0]            op;
    logic [ADDR_WIDTH-1:0] rd;
  } ex_t;

  logic [DATA_WIDTH-1:0] regs [NREG];
  logic [NREG-1:0]       pending, pending_nxt;
  logic [DATA_WIDTH-1:0] read1, read2;
  logic                  hit1, hit2, hitd, hazard, fire;
  ex_t                   ex_q, ex_d;
  logic                  vld_q;

  // Same-cycle write-back both bypasses the read and resolves the pending bit.
  always_comb begin
    hit1   = wb_wen && (wb_waddr == issue_raddr1);
    hit2   = wb_wen && (wb_waddr == issue_raddr2);
    hitd   = wb_wen && (wb_waddr == issue_rd);
    read1  = (issue_raddr1 == '0) ? '0 : (hit1 ? wb_wdata : regs[issue_raddr1]);
    read2  = (issue_raddr2 == '0) ? '0 : (hit2 ? wb_wdata : regs[issue_raddr2]);
    hazard = (pending[issue_raddr1] && !hit1)
          || (!issue_use_imm && pending[issue_raddr2] && !hit2)
          || ((issue_rd != '0) && pending[issue_rd] && !hitd);
  end

  assign issue_ready = !hazard && (!vld_q || ex_ready);
  assign fire        = issue_valid && issue_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wb_wen && (wb_waddr != '0)) begin
      regs[wb_waddr] <= wb_wdata;
    end
  end

  // Set is applied after clear so a same-index issue wins over write-back.
  always_comb begin
    pending_nxt = pending;
    if (wb_wen) pending_nxt[wb_waddr] = 1'b0;
    if (fire && (issue_rd != '0)) pending_nxt[issue_rd] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending <= '0;
    else        pending <= pending_nxt;
  end

  always_comb begin
    ex_d.a  = read1;
    ex_d.b  = issue_use_imm ? issue_imm : read2;
    ex_d.op = issue_aluop;
    ex_d.rd = issue_rd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= 1'b0;
      ex_q  <= '0;
    end else if (fire) begin
      vld_q <= 1'b1;
      ex_q  <= ex_d;
    end else if (ex_ready) begin
      vld_q <= 1'b0;
    end
  end

  assign ex_valid = vld_q;
  assign ex_A     = ex_q.a;
  assign ex_B     = ex_q.b;
  assign ex_ALUop = ex_q.op;
  assign ex_rd    = ex_q.rd;
endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage: hand-computed vectors covering bypass,
// scoreboard stalls, backpressure, r0 handling and asynchronous reset.
module tb_alu_operand_stage;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue_valid, issue_ready, issue_use_imm;
  logic [4:0]  issue_raddr1, issue_raddr2, issue_rd;
  logic [31:0] issue_imm;
  logic [2:0]  issue_aluop;
  logic        wb_wen;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic        ex_valid, ex_ready;
  logic [31:0] ex_A, ex_B;
  logic [2:0]  ex_ALUop;
  logic [4:0]  ex_rd;

  int checks = 0;
  int errors = 0;

  alu_operand_stage #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_raddr1(issue_raddr1), .issue_raddr2(issue_raddr2),
    .issue_use_imm(issue_use_imm), .issue_imm(issue_imm),
    .issue_aluop(issue_aluop), .issue_rd(issue_rd),
    .wb_wen(wb_wen), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_A(ex_A), .ex_B(ex_B), .ex_ALUop(ex_ALUop), .ex_rd(ex_rd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid = 0; issue_raddr1 = 0; issue_raddr2 = 0; issue_use_imm = 0;
    issue_imm = 0; issue_aluop = 0; issue_rd = 0;
    wb_wen = 0; wb_waddr = 0; wb_wdata = 0;
  endtask

  task automatic issue(input logic [4:0] r1, input logic [4:0] r2, input logic [2:0] op,
                       input logic [4:0] rd);
    issue_valid = 1; issue_raddr1 = r1; issue_raddr2 = r2; issue_aluop = op;
    issue_rd = rd; issue_use_imm = 0; issue_imm = 0;
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] d);
    wb_wen = 1; wb_waddr = a; wb_wdata = d;
  endtask

  initial begin
    idle();
    ex_ready = 1;
    rst_n = 0;
    #1;
    chk("rst_valid", {31'd0, ex_valid}, 0);
    chk("rst_A", ex_A, 0);
    chk("rst_B", ex_B, 0);
    chk("rst_op", {29'd0, ex_ALUop}, 0);
    chk("rst_rd", {27'd0, ex_rd}, 0);
    step();
    rst_n = 1;
    step();

    // plain issue from reset-cleared registers
    issue(5, 9, 3'b010, 0);
    #1 chk("t1_ready", {31'd0, issue_ready}, 1);
    step(); idle();
    chk("t1_valid", {31'd0, ex_valid}, 1);
    chk("t1_A", ex_A, 0);
    chk("t1_B", ex_B, 0);
    chk("t1_op", {29'd0, ex_ALUop}, 3'b010);

    // write then read
    wb(3, 32'h10);
    step(); idle();
    issue(3, 0, 3'b000, 0);
    step(); idle();
    chk("t2_A", ex_A, 32'h10);
    chk("t2_B", ex_B, 0);

    // same-cycle bypass on both ports
    wb(7, 32'hDEADBEEF);
    issue(7, 7, 3'b001, 0);
    step(); idle();
    chk("t3_A", ex_A, 32'hDEADBEEF);
    chk("t3_B", ex_B, 32'hDEADBEEF);

    // RAW stall on r4 until write-back
    issue(0, 0, 3'b000, 4);
    step(); idle();
    chk("t4_rd", {27'd0, ex_rd}, 4);
    issue(4, 0, 3'b011, 0);
    for (int i = 0; i < 3; i++) begin
      #1 chk($sformatf("t4_stall%0d", i), {31'd0, issue_ready}, 0);
      step();
    end
    wb(4, 32'd5);
    #1 chk("t4_release", {31'd0, issue_ready}, 1);
    step(); idle();
    chk("t4_A", ex_A, 5);
    chk("t4_valid", {31'd0, ex_valid}, 1);

    // backpressure: payload holds, then back-to-back replacement
    issue(3, 7, 3'd5, 0);
    step();
    ex_ready = 0;
    issue(7, 3, 3'd6, 0);
    for (int i = 0; i < 3; i++) begin
      #1 chk($sformatf("t5_ready%0d", i), {31'd0, issue_ready}, 0);
      step();
      chk($sformatf("t5_hold_v%0d", i), {31'd0, ex_valid}, 1);
      chk($sformatf("t5_hold_A%0d", i), ex_A, 32'h10);
      chk($sformatf("t5_hold_B%0d", i), ex_B, 32'hDEADBEEF);
      chk($sformatf("t5_hold_op%0d", i), {29'd0, ex_ALUop}, 5);
    end
    ex_ready = 1;
    #1 chk("t5_ready_go", {31'd0, issue_ready}, 1);
    step(); idle();
    chk("t5_valid", {31'd0, ex_valid}, 1);
    chk("t5_A", ex_A, 32'hDEADBEEF);
    chk("t5_B", ex_B, 32'h10);
    chk("t5_op", {29'd0, ex_ALUop}, 6);
    step();
    chk("t5_drain", {31'd0, ex_valid}, 0);

    // r0 write discarded; immediate hides pending r9
    issue(0, 0, 3'b000, 9);
    step(); idle();
    wb(0, 32'hFFFFFFFF);
    step(); idle();
    issue(0, 9, 3'b100, 0);
    issue_use_imm = 1; issue_imm = 32'hFFFFFFF0;
    #1 chk("t6_ready", {31'd0, issue_ready}, 1);
    step(); idle();
    chk("t6_A", ex_A, 0);
    chk("t6_B", ex_B, 32'hFFFFFFF0);
    issue(0, 0, 3'b000, 9);
    #1 chk("t6_waw", {31'd0, issue_ready}, 0);
    idle();

    // asynchronous reset mid-transfer
    issue(3, 7, 3'd7, 10);
    step(); idle();
    ex_ready = 0;
    chk("t7_valid_pre", {31'd0, ex_valid}, 1);
    #2 rst_n = 0;
    #1;
    chk("t7_valid_rst", {31'd0, ex_valid}, 0);
    chk("t7_A_rst", ex_A, 0);
    chk("t7_rd_rst", {27'd0, ex_rd}, 0);
    #1 rst_n = 1;
    ex_ready = 1;
    step();
    issue(9, 10, 3'b001, 10);
    #1 chk("t7_sb_clear", {31'd0, issue_ready}, 1);
    idle();
    issue(3, 7, 3'b001, 0);
    step(); idle();
    chk("t7_rf_A", ex_A, 0);
    chk("t7_rf_B", ex_B, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish, expected finish");
    $fatal(1, "timeout");
  end
endmodule
